// File: rtl/priority_encoder_iter_pkg.sv
// -----------------------------------------------------------------------------
// penc_pkg
// Shared types and helpers for the iterative priority encoder.
//   penc_state_t : FSM state encoding (IDLE, SCAN)
//   PENC_MAX_W   : widest request vector the popcount helper handles
//   popcount()   : number of set bits in a vector zero-extended to PENC_MAX_W
// -----------------------------------------------------------------------------
package penc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } penc_state_t;

    localparam int PENC_MAX_W = 256;

    function automatic int unsigned popcount(input logic [PENC_MAX_W-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < PENC_MAX_W; i++) begin
            c = c + {31'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/priority_encoder_iter_prio_enc.sv
// -----------------------------------------------------------------------------
// prio_enc
// Purely combinational priority encoder.
//   vec  in  WIDTH  request vector
//   idx  out IDX_W  index of the highest-priority set bit (0 when vec==0)
//   none out 1      vec is all-zero
// LSB_FIRST=0: bit WIDTH-1 wins. LSB_FIRST=1: bit 0 wins.
// -----------------------------------------------------------------------------
module prio_enc #(
    parameter  int WIDTH     = 8,
    parameter  int LSB_FIRST = 0,
    localparam int IDX_W     = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             none
);
    import penc_pkg::*;

    // The loop walks from lowest to highest priority so the last hit wins.
    always_comb begin
        idx  = '0;
        none = 1'b1;
        if (LSB_FIRST != 0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (vec[i]) begin
                    idx  = IDX_W'(i);
                    none = 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (vec[i]) begin
                    idx  = IDX_W'(i);
                    none = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/priority_encoder_iter.sv
// -----------------------------------------------------------------------------
// priority_encoder_iter
// Accepts a request vector on a valid/ready handshake and emits the index of
// every set bit, one per output handshake, in priority order.
//   clk, reset      rising-edge clock, synchronous active-high reset
//   in_valid/ready  input handshake (ready only in IDLE)
//   in_vec          WIDTH-bit request vector
//   out_valid/ready output handshake
//   out_idx         current highest-priority pending index
//   out_last        final beat of the current vector
//   out_none        accepted vector was all-zero (single beat, idx 0)
//   busy            a vector is in progress
//   out_count       popcount of the last accepted vector (only when the
//                   macro PENC_POPCOUNT_EN is defined)
// -----------------------------------------------------------------------------
module priority_encoder_iter
    import penc_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int LSB_FIRST = 0,
    localparam int IDX_W     = $clog2(WIDTH),
    localparam int CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none,
    output logic             busy
`ifdef PENC_POPCOUNT_EN
    ,
    output logic [CNT_W-1:0] out_count
`endif
);

    penc_state_t      r_state;
    penc_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_pend;
    logic [WIDTH-1:0] w_pend_nxt;
    logic             r_zero;
    logic             w_zero_nxt;
    logic [IDX_W-1:0] w_idx;
    logic             w_enc_none;
    logic             w_single;
    logic             w_last;
    logic             w_scan;

    prio_enc #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_enc (
        .vec  (r_pend),
        .idx  (w_idx),
        .none (w_enc_none)
    );

    // Exactly one bit set: non-zero and clearing the lowest set bit empties it.
    assign w_single = !w_enc_none && ((r_pend & (r_pend - WIDTH'(1))) == '0);
    assign w_scan   = (r_state == SCAN);
    assign w_last   = w_single || r_zero;

    assign in_ready  = !w_scan;
    assign busy      = w_scan;
    assign out_valid = w_scan;
    assign out_idx   = w_scan ? w_idx : '0;
    assign out_last  = w_scan && w_last;
    assign out_none  = w_scan && r_zero;

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_zero_nxt  = r_zero;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_pend_nxt  = in_vec;
                    w_zero_nxt  = (in_vec == '0);
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (out_ready) begin
                    w_pend_nxt = r_pend & ~(WIDTH'(1) << w_idx);
                    if (w_last) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_zero  <= w_zero_nxt;
        end
    end

`ifdef PENC_POPCOUNT_EN
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (in_ready && in_valid) begin
            r_count <= CNT_W'(popcount(PENC_MAX_W'(in_vec)));
        end
    end

    assign out_count = r_count;
`endif

endmodule

// File: tb/tb_priority_encoder_iter.sv
module tb_priority_encoder_iter;

    typedef struct {
        logic [2:0] idx;
        logic       last;
        logic       none;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;

    logic       in_valid0, in_ready0, out_valid0, out_ready0;
    logic [7:0] in_vec0;
    logic [2:0] out_idx0;
    logic       out_last0, out_none0, busy0;

    logic       in_valid1, in_ready1, out_valid1, out_ready1;
    logic [7:0] in_vec1;
    logic [2:0] out_idx1;
    logic       out_last1, out_none1, busy1;

`ifdef PENC_POPCOUNT_EN
    logic [3:0] out_count0, out_count1;
`endif

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    priority_encoder_iter #(.WIDTH(8), .LSB_FIRST(0)) dut0 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_vec(in_vec0),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .out_idx(out_idx0), .out_last(out_last0), .out_none(out_none0),
        .busy(busy0)
`ifdef PENC_POPCOUNT_EN
        , .out_count(out_count0)
`endif
    );

    priority_encoder_iter #(.WIDTH(8), .LSB_FIRST(1)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_vec(in_vec1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_idx(out_idx1), .out_last(out_last1), .out_none(out_none1),
        .busy(busy1)
`ifdef PENC_POPCOUNT_EN
        , .out_count(out_count1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic exp_t mk(input logic [2:0] idx, input logic last, input logic none);
        exp_t e;
        e.idx = idx; e.last = last; e.none = none;
        return e;
    endfunction

    // Scoreboard monitors: every cycle the DUT shows a beat it is compared with
    // the queue head; the head is retired only when the beat is taken.
    always @(negedge clk) begin
        if (out_valid0 === 1'b1) begin
            if (q0.size() == 0) begin
                n_checks++;
                $display("FAIL dut0 unexpected beat: got idx %0d, expected no beat", out_idx0);
            end else begin
                chk("dut0 idx",  {29'd0, out_idx0}, {29'd0, q0[0].idx});
                chk("dut0 last", {31'd0, out_last0}, {31'd0, q0[0].last});
                chk("dut0 none", {31'd0, out_none0}, {31'd0, q0[0].none});
                if (out_ready0) void'(q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_checks++;
                $display("FAIL dut1 unexpected beat: got idx %0d, expected no beat", out_idx1);
            end else begin
                chk("dut1 idx",  {29'd0, out_idx1}, {29'd0, q1[0].idx});
                chk("dut1 last", {31'd0, out_last1}, {31'd0, q1[0].last});
                chk("dut1 none", {31'd0, out_none1}, {31'd0, q1[0].none});
                if (out_ready1) void'(q1.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send0(input logic [7:0] v);
        int t;
        t = 0;
        while (in_ready0 !== 1'b1 && t < 50) begin tick(1); t++; end
        if (t >= 50) begin
            n_checks++;
            $display("FAIL dut0 in_ready timeout: got 0, expected 1");
        end
        in_valid0 = 1'b1; in_vec0 = v;
        tick(1);
        in_valid0 = 1'b0; in_vec0 = 8'h00;
    endtask

    task automatic send1(input logic [7:0] v);
        int t;
        t = 0;
        while (in_ready1 !== 1'b1 && t < 50) begin tick(1); t++; end
        if (t >= 50) begin
            n_checks++;
            $display("FAIL dut1 in_ready timeout: got 0, expected 1");
        end
        in_valid1 = 1'b1; in_vec1 = v;
        tick(1);
        in_valid1 = 1'b0; in_vec1 = 8'h00;
    endtask

    initial begin
        int t;
        reset = 1'b1;
        in_valid0 = 1'b0; in_vec0 = 8'h00; out_ready0 = 1'b1;
        in_valid1 = 1'b0; in_vec1 = 8'h00; out_ready1 = 1'b1;

        // 1. reset state
        tick(2);
        reset = 1'b0;
        chk("reset in_ready",  {31'd0, in_ready0},  32'd1);
        chk("reset out_valid", {31'd0, out_valid0}, 32'd0);
        chk("reset busy",      {31'd0, busy0},      32'd0);
        chk("reset out_idx",   {29'd0, out_idx0},   32'd0);
`ifdef PENC_POPCOUNT_EN
        chk("reset out_count", {28'd0, out_count0}, 32'd0);
`endif

        // 2. A4 streamed: 7, 5, 2(last), in_ready back after three beats
        q0.push_back(mk(3'd7, 1'b0, 1'b0));
        q0.push_back(mk(3'd5, 1'b0, 1'b0));
        q0.push_back(mk(3'd2, 1'b1, 1'b0));
        send0(8'b1010_0100);
        chk("t2 first beat valid", {31'd0, out_valid0}, 32'd1);
        chk("t2 first idx",        {29'd0, out_idx0},   32'd7);
        chk("t2 in_ready low",     {31'd0, in_ready0},  32'd0);
        tick(1);
        chk("t2 second idx",       {29'd0, out_idx0},   32'd5);
        tick(1);
        chk("t2 third idx",        {29'd0, out_idx0},   32'd2);
        tick(1);
        chk("t2 in_ready back",    {31'd0, in_ready0},  32'd1);
        chk("t2 busy clear",       {31'd0, busy0},      32'd0);

        // 3. A4 with a 3-cycle stall on idx 5; inputs during the stall are ignored
        q0.push_back(mk(3'd7, 1'b0, 1'b0));
        q0.push_back(mk(3'd5, 1'b0, 1'b0));
        q0.push_back(mk(3'd2, 1'b1, 1'b0));
        send0(8'b1010_0100);
        tick(1);
        out_ready0 = 1'b0;
        in_valid0 = 1'b1; in_vec0 = 8'hFF;
        tick(3);
        chk("t3 held idx", {29'd0, out_idx0}, 32'd5);
        in_valid0 = 1'b0; in_vec0 = 8'h00;
        out_ready0 = 1'b1;
        tick(1);
        chk("t3 idx after stall", {29'd0, out_idx0}, 32'd2);
        tick(1);
        chk("t3 in_ready back", {31'd0, in_ready0}, 32'd1);

        // 4. all-zero vector: single none beat
        q0.push_back(mk(3'd0, 1'b1, 1'b1));
        send0(8'h00);
        chk("t4 none beat valid", {31'd0, out_valid0}, 32'd1);
        chk("t4 out_none",        {31'd0, out_none0},  32'd1);
        tick(1);
        chk("t4 idle after",      {31'd0, in_ready0},  32'd1);
        chk("t4 out_none clear",  {31'd0, out_none0},  32'd0);

        // 5. LSB_FIRST instance, 81 -> 0 then 7(last)
        q1.push_back(mk(3'd0, 1'b0, 1'b0));
        q1.push_back(mk(3'd7, 1'b1, 1'b0));
        send1(8'h81);
        chk("t5 first idx", {29'd0, out_idx1}, 32'd0);
`ifdef PENC_POPCOUNT_EN
        chk("t5 out_count", {28'd0, out_count1}, 32'd2);
`endif
        tick(1);
        chk("t5 second idx", {29'd0, out_idx1}, 32'd7);
        tick(1);
        chk("t5 in_ready back", {31'd0, in_ready1}, 32'd1);

        // 6. FF with reset after the first beat, then 01
        for (int i = 7; i >= 0; i--) q0.push_back(mk(3'(i), (i == 0), 1'b0));
        send0(8'hFF);
        tick(1);
        reset = 1'b1;
        out_ready0 = 1'b0;
        tick(1);
        q0.delete();
        chk("t6 out_valid after reset", {31'd0, out_valid0}, 32'd0);
        chk("t6 in_ready after reset",  {31'd0, in_ready0},  32'd1);
        reset = 1'b0;
        out_ready0 = 1'b1;
        q0.push_back(mk(3'd0, 1'b1, 1'b0));
        send0(8'h01);
        chk("t6 single idx", {29'd0, out_idx0}, 32'd0);
        chk("t6 single last", {31'd0, out_last0}, 32'd1);

        // drain
        t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 20) begin tick(1); t++; end
        if (t >= 20) begin
            n_checks++;
            $display("FAIL drain: got %0d beats outstanding, expected 0", q0.size() + q1.size());
        end
        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
